// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: definitions shared by the memory-stage load/store unit.
//   - Datapath widths (XLEN, REG_IDX_WIDTH)
//   - LOAD/STORE opcodes and funct3 access-size codes
//   - Two-bit FSM state encoding
//   - Helpers that build store byte enables and lane-replicated store data
package mem_lsu_pkg;

   localparam int unsigned XLEN          = 32;
   localparam int unsigned REG_IDX_WIDTH = 5;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2
   } lsu_state_e;

   // Byte enables for a store of size f3_lo (funct3[1:0]) at byte offset addr_lo.
   function automatic logic [3:0] store_be(input logic [1:0] f3_lo, input logic [1:0] addr_lo);
      logic [3:0] base;
      case (f3_lo)
         2'b00:   base = 4'b0001;
         2'b01:   base = 4'b0011;
         default: base = 4'b1111;
      endcase
      return base << addr_lo;
   endfunction

   // Replicating the datum across the word puts it in every lane, so the
   // byte enables alone pick the destination bytes.
   function automatic logic [XLEN-1:0] store_data(input logic [1:0] f3_lo, input logic [XLEN-1:0] data);
      case (f3_lo)
         2'b00:   return {4{data[7:0]}};
         2'b01:   return {2{data[15:0]}};
         default: return data;
      endcase
   endfunction

endpackage

// File: rtl/dff.sv
// dff: generic enabled register with synchronous active-high reset to zero.
//   clk_i  clock          rst_i  synchronous reset (clears q_o)
//   en_i   load enable    d_i    next value         q_o  registered value
module dff #(
   parameter int unsigned W = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         q_o <= '0;
      end else if (en_i) begin
         q_o <= d_i;
      end
   end

endmodule

// File: rtl/mem_load_ext.sv
// mem_load_ext: combinational load lane select and extension.
//   addr_lo_i  byte offset of the load within the bus word
//   funct3_i   load size/sign code (B, H, W, BU, HU)
//   rdata_i    raw bus word
//   data_o     selected lane, sign- or zero-extended to XLEN
module mem_load_ext
   import mem_lsu_pkg::*;
(
   input  logic [1:0]      addr_lo_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic [XLEN-1:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (addr_lo_i)
         2'd0:    byte_sel = rdata_i[7:0];
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         default: byte_sel = rdata_i[31:24];
      endcase
      half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

      case (funct3_i)
         F3_B:    data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         F3_H:    data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
         F3_BU:   data_o = {{(XLEN-8){1'b0}}, byte_sel};
         F3_HU:   data_o = {{(XLEN-16){1'b0}}, half_sel};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: memory-stage load/store unit.
// Decodes loads/stores from the EX/MEM instruction, runs a valid/ready request
// plus response-valid transaction on the data bus, stalls upstream until the
// access completes, and registers the MEM/WB result (also the ID forwarding source).
//   clk, rst                         clock, synchronous active-high reset
//   mem_pc_i, mem_instr_i            PC / instruction from EX/MEM
//   mem_alu_res_i                    effective address
//   mem_rs2_rdata_i                  store data
//   mem_rd_idx/en/wdata_i            EX-produced writeback
//   dbus_req_valid/ready, addr, we, be, wdata   request channel
//   dbus_rsp_valid_i, dbus_rsp_rdata_i          load response
//   mem_stall_o                      holds EX/MEM and upstream stages
//   mem_wb_pc/instr/rd_idx/rd_en/rd_wdata_o     registered MEM/WB outputs
//   mem_misalign_o                   registered misaligned-access flag
module mem_lsu
   import mem_lsu_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              mem_pc_i,
   input  logic [31:0]              mem_instr_i,
   input  logic [XLEN-1:0]          mem_alu_res_i,
   input  logic [XLEN-1:0]          mem_rs2_rdata_i,
   input  logic [REG_IDX_WIDTH-1:0] mem_rd_idx_i,
   input  logic                     mem_rd_en_i,
   input  logic [XLEN-1:0]          mem_rd_wdata_i,
   output logic                     dbus_req_valid_o,
   input  logic                     dbus_req_ready_i,
   output logic [XLEN-1:0]          dbus_req_addr_o,
   output logic                     dbus_req_we_o,
   output logic [3:0]               dbus_req_be_o,
   output logic [XLEN-1:0]          dbus_req_wdata_o,
   input  logic                     dbus_rsp_valid_i,
   input  logic [XLEN-1:0]          dbus_rsp_rdata_i,
   output logic                     mem_stall_o,
   output logic [31:0]              mem_wb_pc_o,
   output logic [31:0]              mem_wb_instr_o,
   output logic [REG_IDX_WIDTH-1:0] mem_wb_rd_idx_o,
   output logic                     mem_wb_rd_en_o,
   output logic [XLEN-1:0]          mem_wb_rd_wdata_o,
   output logic                     mem_misalign_o
);

   // ---------------- decode ----------------
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [1:0] addr_lo;
   logic       is_load, is_store, f3_ok, misalign, bus_op, fault;

   assign opcode   = mem_instr_i[6:0];
   assign funct3   = mem_instr_i[14:12];
   assign addr_lo  = mem_alu_res_i[1:0];
   assign is_load  = (opcode == OPC_LOAD);
   assign is_store = (opcode == OPC_STORE);

   always_comb begin
      f3_ok = 1'b0;
      if (is_load) begin
         f3_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
      end else if (is_store) begin
         f3_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
      end
   end

   // funct3[1:0] is the access size for both signed and unsigned loads.
   assign misalign = f3_ok && (((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                               ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00)));
   assign bus_op   = f3_ok && !misalign;
   // Faulting mem ops (misaligned or unsupported size) skip the bus and retire in one cycle.
   assign fault    = (is_load || is_store) && !bus_op;

   // ---------------- bus FSM ----------------
   lsu_state_e state_q, state_d;
   logic       req_valid, done, stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      req_valid = 1'b0;
      done      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus_op) state_d = ST_REQ;
         end
         ST_REQ: begin
            req_valid = 1'b1;
            if (dbus_req_ready_i) begin
               if (is_store) begin
                  done    = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_RSP;
               end
            end
         end
         ST_RSP: begin
            // Responses arriving in any other state are simply never looked at.
            if (dbus_rsp_valid_i) begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign stall = bus_op && !done;

   // Request fields come straight from EX/MEM, which the stall keeps stable
   // for the whole REQ phase; they are zeroed whenever no request is offered.
   logic req_out;
   assign req_out          = req_valid && !rst;
   assign dbus_req_valid_o = req_out;
   assign dbus_req_addr_o  = req_out ? {mem_alu_res_i[XLEN-1:2], 2'b00} : '0;
   assign dbus_req_we_o    = req_out && is_store;
   assign dbus_req_be_o    = req_out ? store_be(funct3[1:0], addr_lo) : 4'b0000;
   assign dbus_req_wdata_o = (req_out && is_store) ? store_data(funct3[1:0], mem_rs2_rdata_i) : '0;
   assign mem_stall_o      = stall && !rst;

   // ---------------- load extension ----------------
   logic [XLEN-1:0] load_data;

   mem_load_ext u_load_ext (
      .addr_lo_i (addr_lo),
      .funct3_i  (funct3),
      .rdata_i   (dbus_rsp_rdata_i),
      .data_o    (load_data)
   );

   // ---------------- MEM/WB registers ----------------
   // While stalled, a bubble is loaded: rd_en/misalign cleared, the rest held.
   logic                     wb_en;
   logic                     rd_en_d, misalign_d;
   logic [XLEN-1:0]          rd_wdata_d;

   assign wb_en      = !stall;
   assign rd_en_d    = stall ? 1'b0 :
                       fault ? 1'b0 :
                       bus_op ? (is_load && mem_rd_en_i) : mem_rd_en_i;
   assign misalign_d = !stall && misalign;
   assign rd_wdata_d = (bus_op && is_load) ? load_data : mem_rd_wdata_i;

   dff #(.W(32)) u_wb_pc (
      .clk_i(clk), .rst_i(rst), .en_i(wb_en), .d_i(mem_pc_i), .q_o(mem_wb_pc_o)
   );
   dff #(.W(32)) u_wb_instr (
      .clk_i(clk), .rst_i(rst), .en_i(wb_en), .d_i(mem_instr_i), .q_o(mem_wb_instr_o)
   );
   dff #(.W(REG_IDX_WIDTH)) u_wb_rd_idx (
      .clk_i(clk), .rst_i(rst), .en_i(wb_en), .d_i(mem_rd_idx_i), .q_o(mem_wb_rd_idx_o)
   );
   dff #(.W(XLEN)) u_wb_rd_wdata (
      .clk_i(clk), .rst_i(rst), .en_i(wb_en), .d_i(rd_wdata_d), .q_o(mem_wb_rd_wdata_o)
   );
   dff #(.W(1)) u_wb_rd_en (
      .clk_i(clk), .rst_i(rst), .en_i(1'b1), .d_i(rd_en_d), .q_o(mem_wb_rd_en_o)
   );
   dff #(.W(1)) u_wb_misalign (
      .clk_i(clk), .rst_i(rst), .en_i(1'b1), .d_i(misalign_d), .q_o(mem_misalign_o)
   );

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed, table-driven bench for mem_lsu plus hand-written
// sequences for reset during a pending response.
module tb_mem_lsu;
   import mem_lsu_pkg::*;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [31:0]              mem_pc_i, mem_instr_i;
   logic [XLEN-1:0]          mem_alu_res_i, mem_rs2_rdata_i, mem_rd_wdata_i;
   logic [REG_IDX_WIDTH-1:0] mem_rd_idx_i;
   logic                     mem_rd_en_i;
   logic                     dbus_req_valid_o, dbus_req_ready_i, dbus_req_we_o;
   logic [XLEN-1:0]          dbus_req_addr_o, dbus_req_wdata_o;
   logic [3:0]               dbus_req_be_o;
   logic                     dbus_rsp_valid_i;
   logic [XLEN-1:0]          dbus_rsp_rdata_i;
   logic                     mem_stall_o;
   logic [31:0]              mem_wb_pc_o, mem_wb_instr_o;
   logic [REG_IDX_WIDTH-1:0] mem_wb_rd_idx_o;
   logic                     mem_wb_rd_en_o;
   logic [XLEN-1:0]          mem_wb_rd_wdata_o;
   logic                     mem_misalign_o;

   mem_lsu dut (
      .clk(clk), .rst(rst),
      .mem_pc_i(mem_pc_i), .mem_instr_i(mem_instr_i),
      .mem_alu_res_i(mem_alu_res_i), .mem_rs2_rdata_i(mem_rs2_rdata_i),
      .mem_rd_idx_i(mem_rd_idx_i), .mem_rd_en_i(mem_rd_en_i), .mem_rd_wdata_i(mem_rd_wdata_i),
      .dbus_req_valid_o(dbus_req_valid_o), .dbus_req_ready_i(dbus_req_ready_i),
      .dbus_req_addr_o(dbus_req_addr_o), .dbus_req_we_o(dbus_req_we_o),
      .dbus_req_be_o(dbus_req_be_o), .dbus_req_wdata_o(dbus_req_wdata_o),
      .dbus_rsp_valid_i(dbus_rsp_valid_i), .dbus_rsp_rdata_i(dbus_rsp_rdata_i),
      .mem_stall_o(mem_stall_o),
      .mem_wb_pc_o(mem_wb_pc_o), .mem_wb_instr_o(mem_wb_instr_o),
      .mem_wb_rd_idx_o(mem_wb_rd_idx_o), .mem_wb_rd_en_o(mem_wb_rd_en_o),
      .mem_wb_rd_wdata_o(mem_wb_rd_wdata_o), .mem_misalign_o(mem_misalign_o)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   localparam logic [31:0] NOP = 32'h0000_0013;

   function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
      return {17'd0, f3, 5'd0, opc};
   endfunction

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [31:0] addr;
      logic [31:0] rs2;
      logic [4:0]  rd_idx;
      logic        rd_en;
      logic [31:0] rd_wdata;
      logic [31:0] rsp_rdata;
      int          rdy_dly;
      int          rsp_dly;
      bit          stray;
      bit          e_bus;
      logic [31:0] e_addr;
      logic        e_we;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic        e_rd_en;
      logic [31:0] e_rd_wdata;
      logic        e_mis;
      int          e_cycles;
      int          e_stalls;
   } vec_t;

   task automatic idle_inputs();
      mem_instr_i      = NOP;
      mem_alu_res_i    = '0;
      mem_rs2_rdata_i  = '0;
      mem_rd_idx_i     = '0;
      mem_rd_en_i      = 1'b0;
      mem_rd_wdata_i   = '0;
      dbus_req_ready_i = 1'b0;
      dbus_rsp_valid_i = 1'b0;
      dbus_rsp_rdata_i = '0;
   endtask

   // Called #1 after a rising edge; returns #1 after the edge that retires the op.
   task automatic run_op(input vec_t v, input logic [31:0] pc);
      int  rdy_wait, rsp_wait, cycles, stalls;
      bit  fin, hs, rsp_phase;
      logic [31:0] b_addr, b_wdata;
      logic        b_we;
      logic [3:0]  b_be;
      mem_pc_i        = pc;
      mem_instr_i     = v.instr;
      mem_alu_res_i   = v.addr;
      mem_rs2_rdata_i = v.rs2;
      mem_rd_idx_i    = v.rd_idx;
      mem_rd_en_i     = v.rd_en;
      mem_rd_wdata_i  = v.rd_wdata;
      rdy_wait = 0; rsp_wait = 0; cycles = 0; stalls = 0;
      fin = 0; hs = 0; rsp_phase = 0;
      b_addr = '0; b_wdata = '0; b_we = 1'b0; b_be = '0;
      for (int c = 0; c < 40 && !fin; c++) begin
         @(negedge clk);
         dbus_req_ready_i = dbus_req_valid_o && (rdy_wait >= v.rdy_dly);
         if (dbus_req_valid_o) rdy_wait++;
         dbus_rsp_valid_i = (rsp_phase && (rsp_wait >= v.rsp_dly)) || (v.stray && c == 0);
         dbus_rsp_rdata_i = (rsp_phase && (rsp_wait >= v.rsp_dly)) ? v.rsp_rdata : 32'hDEAD_BEEF;
         if (rsp_phase) rsp_wait++;
         #1;
         if (dbus_req_valid_o && dbus_req_ready_i) begin
            hs = 1; rsp_phase = 1;
            b_addr = dbus_req_addr_o; b_we = dbus_req_we_o;
            b_be = dbus_req_be_o; b_wdata = dbus_req_wdata_o;
         end
         cycles++;
         if (mem_stall_o) stalls++;
         else fin = 1;
      end
      if (!fin) begin
         errors++; checks++;
         $display("FAIL %s timeout: stall still high after %0d cycles", v.name, cycles);
      end
      @(posedge clk); #1;
      dbus_req_ready_i = 1'b0;
      dbus_rsp_valid_i = 1'b0;
      idle_inputs();
      chk({v.name, " cycles"}, cycles, v.e_cycles);
      chk({v.name, " stalls"}, stalls, v.e_stalls);
      chk({v.name, " bus_used"}, {31'd0, hs}, {31'd0, v.e_bus});
      if (v.e_bus) begin
         chk({v.name, " addr"}, b_addr, v.e_addr);
         chk({v.name, " we"}, {31'd0, b_we}, {31'd0, v.e_we});
         chk({v.name, " be"}, {28'd0, b_be}, {28'd0, v.e_be});
         if (v.e_we) chk({v.name, " bus_wdata"}, b_wdata, v.e_wdata);
      end
      chk({v.name, " wb_rd_en"}, {31'd0, mem_wb_rd_en_o}, {31'd0, v.e_rd_en});
      chk({v.name, " misalign"}, {31'd0, mem_misalign_o}, {31'd0, v.e_mis});
      chk({v.name, " wb_pc"}, mem_wb_pc_o, pc);
      if (v.e_rd_en) begin
         chk({v.name, " wb_rd_wdata"}, mem_wb_rd_wdata_o, v.e_rd_wdata);
         chk({v.name, " wb_rd_idx"}, {27'd0, mem_wb_rd_idx_o}, {27'd0, v.rd_idx});
      end
   endtask

   vec_t vecs[12];
   vec_t lw_after;

   initial begin
      // name instr addr rs2 rd rd_en rd_wdata rsp_rdata rdy rsp stray | bus addr we be wdata rd_en rd_wdata mis cyc stalls
      vecs[0]  = '{"ADD", 32'h0000_0033, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 32'h0, 0, 0, 0,
                   0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h1234, 1'b0, 1, 0};
      vecs[1]  = '{"LB", mk(OPC_LOAD, F3_B), 32'h103, 32'h0, 5'd6, 1'b1, 32'h0, 32'h80FF_FF00, 0, 0, 0,
                   1, 32'h100, 1'b0, 4'b1000, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0, 3, 2};
      vecs[2]  = '{"SH", mk(OPC_STORE, F3_H), 32'h102, 32'h0000_ABCD, 5'd0, 1'b0, 32'h0, 32'h0, 2, 0, 0,
                   1, 32'h100, 1'b1, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0, 1'b0, 4, 3};
      vecs[3]  = '{"LW_mis", mk(OPC_LOAD, F3_W), 32'h101, 32'h0, 5'd7, 1'b1, 32'h0, 32'h0, 0, 0, 0,
                   0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1, 0};
      vecs[4]  = '{"LHU", mk(OPC_LOAD, F3_HU), 32'h202, 32'h0, 5'd8, 1'b1, 32'h0, 32'h9876_5432, 0, 4, 1,
                   1, 32'h200, 1'b0, 4'b1100, 32'h0, 1'b1, 32'h0000_9876, 1'b0, 7, 6};
      vecs[5]  = '{"SB", mk(OPC_STORE, F3_B), 32'h101, 32'h1234_56AB, 5'd0, 1'b0, 32'h0, 32'h0, 0, 0, 0,
                   1, 32'h100, 1'b1, 4'b0010, 32'hABAB_ABAB, 1'b0, 32'h0, 1'b0, 2, 1};
      vecs[6]  = '{"SW", mk(OPC_STORE, F3_W), 32'h3C, 32'hCAFE_F00D, 5'd0, 1'b0, 32'h0, 32'h0, 1, 0, 0,
                   1, 32'h3C, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, 3, 2};
      vecs[7]  = '{"LH", mk(OPC_LOAD, F3_H), 32'h102, 32'h0, 5'd9, 1'b1, 32'h0, 32'h8001_0000, 0, 1, 0,
                   1, 32'h100, 1'b0, 4'b1100, 32'h0, 1'b1, 32'hFFFF_8001, 1'b0, 4, 3};
      vecs[8]  = '{"LBU", mk(OPC_LOAD, F3_BU), 32'h101, 32'h0, 5'd10, 1'b1, 32'h0, 32'h0000_F000, 0, 0, 0,
                   1, 32'h100, 1'b0, 4'b0010, 32'h0, 1'b1, 32'h0000_00F0, 1'b0, 3, 2};
      vecs[9]  = '{"LD_badf3", mk(OPC_LOAD, 3'b011), 32'h100, 32'h0, 5'd11, 1'b1, 32'h0, 32'h0, 0, 0, 0,
                   0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1, 0};
      vecs[10] = '{"SH_mis", mk(OPC_STORE, F3_H), 32'h103, 32'h1111, 5'd0, 1'b0, 32'h0, 32'h0, 0, 0, 0,
                   0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1, 0};
      vecs[11] = '{"LW", mk(OPC_LOAD, F3_W), 32'h204, 32'h0, 5'd12, 1'b1, 32'h0, 32'h0102_0304, 0, 0, 0,
                   1, 32'h204, 1'b0, 4'b1111, 32'h0, 1'b1, 32'h0102_0304, 1'b0, 3, 2};
      lw_after = '{"LW_post_rst", mk(OPC_LOAD, F3_W), 32'h300, 32'h0, 5'd13, 1'b1, 32'h0, 32'h5A5A_1234, 0, 0, 0,
                   1, 32'h300, 1'b0, 4'b1111, 32'h0, 1'b1, 32'h5A5A_1234, 1'b0, 3, 2};

      rst = 1'b1;
      mem_pc_i = 32'h0;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst valid", {31'd0, dbus_req_valid_o}, 32'd0);
      chk("rst stall", {31'd0, mem_stall_o}, 32'd0);
      chk("rst wb_rd_en", {31'd0, mem_wb_rd_en_o}, 32'd0);
      chk("rst wb_wdata", mem_wb_rd_wdata_o, 32'd0);
      chk("rst wb_pc", mem_wb_pc_o, 32'd0);
      chk("rst misalign", {31'd0, mem_misalign_o}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Back-to-back: each op is applied right after the previous one retires.
      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i], 32'h1000 + 32'(i) * 4);
      end

      // Reset while a load waits in RSP.
      mem_pc_i      = 32'h2000;
      mem_instr_i   = mk(OPC_LOAD, F3_W);
      mem_alu_res_i = 32'h300;
      mem_rd_idx_i  = 5'd14;
      mem_rd_en_i   = 1'b1;
      @(negedge clk);
      chk("rr idle stall", {31'd0, mem_stall_o}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rr req valid", {31'd0, dbus_req_valid_o}, 32'd1);
      dbus_req_ready_i = 1'b1;
      @(posedge clk); #1;
      dbus_req_ready_i = 1'b0;
      @(negedge clk);
      chk("rr rsp valid", {31'd0, dbus_req_valid_o}, 32'd0);
      chk("rr rsp stall", {31'd0, mem_stall_o}, 32'd1);
      rst = 1'b1;
      idle_inputs();
      mem_pc_i = 32'h0;
      #1;
      chk("rr rst valid", {31'd0, dbus_req_valid_o}, 32'd0);
      chk("rr rst stall", {31'd0, mem_stall_o}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rr wb_pc", mem_wb_pc_o, 32'd0);
      chk("rr wb_instr", mem_wb_instr_o, 32'd0);
      chk("rr wb_rd_en", {31'd0, mem_wb_rd_en_o}, 32'd0);
      chk("rr wb_wdata", mem_wb_rd_wdata_o, 32'd0);
      chk("rr wb_idx", {27'd0, mem_wb_rd_idx_o}, 32'd0);
      // Late response arrives alongside a plain ALU op and must not disturb it.
      mem_pc_i         = 32'h2004;
      mem_instr_i      = 32'h0000_0033;
      mem_rd_idx_i     = 5'd7;
      mem_rd_en_i      = 1'b1;
      mem_rd_wdata_i   = 32'h55;
      dbus_rsp_valid_i = 1'b1;
      dbus_rsp_rdata_i = 32'hDEAD_0000;
      @(negedge clk);
      chk("late rsp stall", {31'd0, mem_stall_o}, 32'd0);
      chk("late rsp valid", {31'd0, dbus_req_valid_o}, 32'd0);
      @(posedge clk); #1;
      dbus_rsp_valid_i = 1'b0;
      chk("late rsp wb_wdata", mem_wb_rd_wdata_o, 32'h55);
      chk("late rsp wb_rd_en", {31'd0, mem_wb_rd_en_o}, 32'd1);
      idle_inputs();
      run_op(lw_after, 32'h2008);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-stage load/store unit sitting directly downstream of the EX/MEM pipeline register. Consumes the registered EX results, decodes loads and stores from the instruction word, and runs a valid/ready request plus response-valid transaction on the data bus. Stalls the pipeline until the access completes, then extends and aligns load data and drives the registered MEM/WB outputs, which are also the MEM-stage forwarding source for ID.

## Interface
- XLEN, 32, data and address width
- REG_IDX_WIDTH, 5, register index width
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- mem_pc_i / mem_instr_i  in  32/32  PC and instruction from EX/MEM
- mem_alu_res_i  in  XLEN  effective address for loads/stores
- mem_rs2_rdata_i  in  XLEN  store data
- mem_rd_idx_i / mem_rd_en_i / mem_rd_wdata_i  in  5/1/XLEN  EX-produced writeback
- dbus_req_valid_o  out  1  request valid
- dbus_req_ready_i  in  1  request accepted when high together with valid
- dbus_req_addr_o  out  XLEN  word-aligned address, {addr[XLEN-1:2],2'b00}
- dbus_req_we_o / dbus_req_be_o / dbus_req_wdata_o  out  1/4/XLEN  write, byte enables, lane-shifted data
- dbus_rsp_valid_i / dbus_rsp_rdata_i  in  1/XLEN  load response
- mem_stall_o  out  1  holds EX/MEM and upstream
- mem_wb_pc_o / mem_wb_instr_o  out  32/32  registered to WB
- mem_wb_rd_idx_o / mem_wb_rd_en_o / mem_wb_rd_wdata_o  out  5/1/XLEN  registered writeback, forwarded to ID
- mem_misalign_o  out  1  registered, high with the faulting instruction in WB

## Operation
- Decode: opcode 0000011 = load, 0100011 = store; funct3 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only).
- Misaligned (H with addr[0]=1, W with addr[1:0]!=0) or unsupported funct3: no bus access, completes in one cycle, rd_en forced 0; misalign flag set only for the misaligned case.
- Non-memory instructions: pass through in one cycle, stall 0, rd_wdata = mem_rd_wdata_i.
- FSM states IDLE, REQ, RSP. IDLE: valid mem op → REQ, stall 1. REQ: valid_o=1, addr/we/be/wdata held stable until ready; on handshake store → IDLE (done), load → RSP. RSP: wait dbus_rsp_valid_i, capture → IDLE (done).
- mem_stall_o = mem op present AND not done this cycle (combinational). On the done cycle stall is 0, EX/MEM advances and the MEM/WB registers capture.
- Byte enables: B 0001, H 0011, W 1111, shifted left by addr[1:0]. wdata: byte replicated ×4, half replicated ×2, word as-is.
- Load data: lane selected by addr[1:0], sign-extended (B/H) or zero-extended (BU/HU).
- While stall is high, MEM/WB registers load a bubble: rd_en 0, misalign 0 (pc/instr hold).
- dbus_rsp_valid_i outside RSP is ignored.

## Timing
- Reset: state IDLE; all outputs 0; valid_o 0 in the reset cycle.
- Non-mem / faulting op: 1 cycle, result visible on mem_wb_* next edge.
- Store: minimum 2 cycles (IDLE, REQ with ready=1). Load: minimum 3 cycles (IDLE, REQ, RSP with rsp_valid=1).
- Each ready or rsp wait cycle adds one cycle of stall.
- Reset asserted mid-transaction: FSM to IDLE next edge, request dropped, late response ignored.
- Back-to-back mem ops: new op enters IDLE the cycle after done; no bubble cycle required beyond the FSM.

## Structure
- Shared defines: LOAD/STORE opcodes, funct3 size codes, FSM state encoding (2 bits), XLEN/REG_IDX_WIDTH.
- Sub-module mem_load_ext: combinational lane select plus sign/zero extension (addr[1:0], funct3, rdata → XLEN).
- MEM/WB registers built from the existing dff cell.

## Test plan
- ADD, rd=5, wdata=0x1234 → next cycle mem_wb_rd_en=1, idx=5, wdata=0x1234, stall never high.
- LB addr 0x103, rsp rdata 0x80FF_FF00 → be n/a, wdata=0xFFFF_FF80, load done 3 cycles after entry with ready and rsp immediate.
- SH addr 0x102, rs2=0xABCD → addr 0x100, be 1100, wdata 0xABCD_ABCD, we=1; ready delayed 2 cycles → stall high 3 cycles.
- LW addr 0x101 → no valid_o, mem_misalign_o=1, rd_en=0 next cycle.
- LHU addr 0x202 with rsp delayed 4 cycles and stray rsp_valid in IDLE before it → stray ignored, result 0x0000_xxxx from upper half.
- rst pulsed during RSP → valid_o 0, all outputs 0, later rsp_valid ignored, next LW completes normally.
